// File: rtl/hdmi_cfg_if.sv
// Byte-level I2C master request/response bus between the HDMI configuration
// sequencer (master side) and the external I2C engine (slave side).
interface hdmi_cfg_if;
  logic       i2c_req;
  logic       i2c_rw;
  logic [6:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_wdata;
  logic       i2c_done;
  logic       i2c_nack;
  logic [7:0] i2c_rdata;

  modport master (
    output i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
    input  i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
    output i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/hdmi_cfg_seq.sv
// HDMI transmitter power-up/hot-plug register configuration sequencer.
// Optional read-back verification of every write is enabled by HDMI_CFG_VERIFY_EN.
module hdmi_cfg_seq #(
  parameter logic [6:0] DEV_ADDR     = 7'h39,
  parameter int         PWRUP_CYCLES = 200000,
  parameter int         MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hpd,
  input  logic       cfg_restart,
  hdmi_cfg_if.master bus,
  output logic       video_en,
  output logic       cfg_err,
  output logic [2:0] cfg_idx
);
  localparam int NUM_WR = 6;
  localparam int DW     = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam logic [DW-1:0] DLY_LAST  = DW'(PWRUP_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_WR - 1);
  // Entry i occupies bits [16*i +: 16] as {reg, data}.
  localparam logic [16*NUM_WR-1:0] TABLE = {
    16'hAF06, 16'h1630, 16'h1505, 16'h9AE0, 16'h9803, 16'h4110
  };

  typedef enum logic [2:0] {
    IDLE, PWR_WAIT, ISSUE, WAIT, VERIFY, DONE, ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [DW-1:0] dly_reg, dly_next;
  logic [1:0]    retry_reg, retry_next;
  logic [2:0]    idx_reg, idx_next;
  logic          req_reg, req_next;
  logic          rw_reg, rw_next;
  logic [6:0]    dev_reg, dev_next;
  logic [7:0]    reg_reg, reg_next;
  logic [7:0]    wdata_reg, wdata_next;
  logic          hpd_lost_reg, hpd_lost_next;
  logic          restart_pend_reg, restart_pend_next;
  logic          xfer_ok;
  logic          need_verify;

  logic [7:0] tbl_reg  [NUM_WR];
  logic [7:0] tbl_data [NUM_WR];

  generate
    for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_tbl
      assign tbl_reg[gi]  = TABLE[16*gi+8 +: 8];
      assign tbl_data[gi] = TABLE[16*gi   +: 8];
    end
  endgenerate

`ifdef HDMI_CFG_VERIFY_EN
  // A read completes well only if the register holds what was just written.
  assign xfer_ok     = !bus.i2c_nack && (!rw_reg || (bus.i2c_rdata == wdata_reg));
  assign need_verify = !rw_reg;
  assign bus.i2c_rw  = rw_reg;
`else
  logic unused_sigs;
  assign unused_sigs = ^{bus.i2c_rdata, rw_reg};
  assign xfer_ok     = !bus.i2c_nack;
  assign need_verify = 1'b0;
  assign bus.i2c_rw  = 1'b0;
`endif

  assign bus.i2c_req   = req_reg;
  assign bus.i2c_dev   = dev_reg;
  assign bus.i2c_reg   = reg_reg;
  assign bus.i2c_wdata = wdata_reg;
  assign cfg_idx       = idx_reg;
  assign cfg_err       = (state_reg == ERROR);
  assign video_en      = (state_reg == DONE) && hpd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      dly_reg          <= '0;
      retry_reg        <= '0;
      idx_reg          <= '0;
      req_reg          <= 1'b0;
      rw_reg           <= 1'b0;
      dev_reg          <= '0;
      reg_reg          <= '0;
      wdata_reg        <= '0;
      hpd_lost_reg     <= 1'b0;
      restart_pend_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      dly_reg          <= dly_next;
      retry_reg        <= retry_next;
      idx_reg          <= idx_next;
      req_reg          <= req_next;
      rw_reg           <= rw_next;
      dev_reg          <= dev_next;
      reg_reg          <= reg_next;
      wdata_reg        <= wdata_next;
      hpd_lost_reg     <= hpd_lost_next;
      restart_pend_reg <= restart_pend_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    dly_next          = dly_reg;
    retry_next        = retry_reg;
    idx_next          = idx_reg;
    req_next          = req_reg;
    rw_next           = rw_reg;
    dev_next          = dev_reg;
    reg_next          = reg_reg;
    wdata_next        = wdata_reg;
    hpd_lost_next     = hpd_lost_reg;
    restart_pend_next = restart_pend_reg;

    case (state_reg)
      IDLE: begin
        if (hpd) begin
          state_next = PWR_WAIT;
          dly_next   = '0;
        end
      end
      PWR_WAIT: begin
        if (!hpd) begin
          state_next = IDLE;
        end else if (dly_reg == DLY_LAST) begin
          state_next = ISSUE;
          idx_next   = '0;
          retry_next = '0;
        end else begin
          dly_next = dly_reg + DW'(1);
        end
      end
      ISSUE: begin
        if (!hpd) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
          req_next   = 1'b1;
          rw_next    = 1'b0;
          dev_next   = DEV_ADDR;
          reg_next   = tbl_reg[idx_reg];
          wdata_next = tbl_data[idx_reg];
        end
      end
`ifdef HDMI_CFG_VERIFY_EN
      VERIFY: begin
        if (!hpd) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
          req_next   = 1'b1;
          rw_next    = 1'b1;
        end
      end
`endif
      WAIT: begin
        // HPD loss and restart are remembered so the transaction can finish first.
        if (!hpd)        hpd_lost_next     = 1'b1;
        if (cfg_restart) restart_pend_next = 1'b1;
        if (bus.i2c_done) begin
          req_next          = 1'b0;
          hpd_lost_next     = 1'b0;
          restart_pend_next = 1'b0;
          if (!hpd || hpd_lost_reg) begin
            state_next = IDLE;
          end else if (cfg_restart || restart_pend_reg) begin
            state_next = PWR_WAIT;
            dly_next   = '0;
          end else if (xfer_ok && need_verify) begin
            state_next = VERIFY;
          end else if (xfer_ok) begin
            if (idx_reg == IDX_LAST) begin
              state_next = DONE;
            end else begin
              state_next = ISSUE;
              idx_next   = idx_reg + 3'd1;
              retry_next = '0;
            end
          end else begin
            if (retry_reg != 2'd3) retry_next = retry_reg + 2'd1;
            if (({1'b0, retry_reg} + 3'd1) >= {1'b0, RETRY_MAX}) state_next = ERROR;
            else                                                 state_next = ISSUE;
          end
        end
      end
      DONE, ERROR: begin
        if (!hpd) begin
          state_next = IDLE;
        end else if (cfg_restart) begin
          state_next = PWR_WAIT;
          dly_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Self-checking bench for hdmi_cfg_seq: randomized I2C slave responses checked
// against a transaction-level model of the configuration table walk.
module tb_hdmi_cfg_seq;
  localparam int         PWR  = 4;
  localparam int         MAXR = 3;
  localparam logic [6:0] DEV  = 7'h39;

  typedef struct packed {
    logic       rw;
    logic [7:0] r;
    logic [7:0] d;
    logic       nack;
  } tx_t;

  logic       clk = 1'b0;
  logic       rst, hpd, cfg_restart;
  logic       video_en, cfg_err;
  logic [2:0] cfg_idx;

  hdmi_cfg_if bus ();

  hdmi_cfg_seq #(.DEV_ADDR(DEV), .PWRUP_CYCLES(PWR), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .hpd(hpd), .cfg_restart(cfg_restart), .bus(bus),
    .video_en(video_en), .cfg_err(cfg_err), .cfg_idx(cfg_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 3;
  int n_started = 0;
  logic [7:0] t_reg [6];
  logic [7:0] t_dat [6];
  int   nack_cfg [256];
  int   bad_cfg  [256];
  int   nack_left[256];
  int   bad_left [256];
  logic [7:0] dev_mem [256];
  tx_t  tx_q[$];
  tx_t  exp_q[$];

  // Responding I2C engine: fixed latency, NACK/bad-readback budgets per register.
  initial begin : slave
    bit  busy;
    bit  prev_req;
    bit  nk;
    int  cnt;
    tx_t cur;
    busy = 0; prev_req = 0; cnt = 0; cur = '0;
    bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0; bus.i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      if (rst) begin
        busy = 0;
      end else begin
        if (!busy && bus.i2c_req) begin
          checks++;
          if (prev_req) begin
            errors++;
            $display("FAIL gap: req=%0d with no idle cycle, required 0", bus.i2c_req);
          end
          checks++;
          if (bus.i2c_dev !== DEV) begin
            errors++;
            $display("FAIL dev: got %h, required %h", bus.i2c_dev, DEV);
          end
          cur = '{rw: bus.i2c_rw, r: bus.i2c_reg, d: bus.i2c_wdata, nack: 1'b0};
          busy = 1; cnt = lat - 1; n_started++;
        end else if (busy) begin
          checks++;
          if (bus.i2c_req !== 1'b1) begin
            errors++;
            $display("FAIL req_held: req=%0d before done, required 1", bus.i2c_req);
            busy = 0;
          end else if ({bus.i2c_rw, bus.i2c_reg, bus.i2c_wdata} !== {cur.rw, cur.r, cur.d}) begin
            errors++;
            $display("FAIL stable: fields %h/%h/%h, required %h/%h/%h", bus.i2c_rw,
                     bus.i2c_reg, bus.i2c_wdata, cur.rw, cur.r, cur.d);
          end
        end
        if (busy && bus.i2c_req) begin
          if (cnt == 0) begin
            nk = 0;
            if (!cur.rw) begin
              if (nack_left[cur.r] > 0) begin
                nk = 1;
                nack_left[cur.r]--;
              end else begin
                dev_mem[cur.r] = cur.d;
              end
              bus.i2c_rdata = 8'h00;
            end else if (bad_left[cur.r] > 0) begin
              bad_left[cur.r]--;
              bus.i2c_rdata = 8'h00;
            end else begin
              bus.i2c_rdata = dev_mem[cur.r];
            end
            cur.nack = nk;
            tx_q.push_back(cur);
            bus.i2c_done = 1'b1;
            bus.i2c_nack = nk;
            busy = 0;
          end else begin
            cnt--;
          end
        end
      end
      prev_req = bus.i2c_req;
    end
  end

  // Transaction-level expectation: walk the table, counting failed attempts per entry.
  task automatic build_expected(output bit exp_err);
    int  nk[256];
`ifdef HDMI_CFG_VERIFY_EN
    int  bd[256];
`endif
    int  fails;
    bit  ok;
    tx_t t;
    nk = nack_cfg;
`ifdef HDMI_CFG_VERIFY_EN
    bd = bad_cfg;
`endif
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < 6 && !exp_err; i++) begin
      fails = 0;
      ok = 0;
      while (!ok && !exp_err) begin
        t = '{rw: 1'b0, r: t_reg[i], d: t_dat[i], nack: (nk[t_reg[i]] > 0)};
        exp_q.push_back(t);
        if (t.nack) begin
          nk[t.r]--;
          fails++;
        end else begin
`ifdef HDMI_CFG_VERIFY_EN
          t.rw = 1'b1;
          exp_q.push_back(t);
          if (bd[t.r] > 0) begin
            bd[t.r]--;
            fails++;
          end else ok = 1;
`else
          ok = 1;
`endif
        end
        if (!ok && fails == MAXR) exp_err = 1;
      end
    end
  endtask

  function automatic int log_mismatch();
    if (tx_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) begin
      if (tx_q[i].rw !== exp_q[i].rw || tx_q[i].r !== exp_q[i].r ||
          tx_q[i].nack !== exp_q[i].nack || (!exp_q[i].rw && tx_q[i].d !== exp_q[i].d))
        return i;
    end
    return -1;
  endfunction

  task automatic clear_policy();
    foreach (nack_cfg[i]) begin
      nack_cfg[i] = 0;
      bad_cfg[i] = 0;
    end
  endtask

  task automatic arm();
    nack_left = nack_cfg;
    bad_left = bad_cfg;
    tx_q.delete();
  endtask

  task automatic measure_latency(output int n);
    n = 0;
    @(posedge clk);
    while (n < 100) begin
      @(negedge clk);
      if (bus.i2c_req) break;
      n++;
      @(posedge clk);
    end
  endtask

  task automatic wait_end(input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (video_en || cfg_err) break;
      @(negedge clk);
    end
    if (k == 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no video_en/cfg_err after %0d cycles, required completion", name, k);
    end
  endtask

  task automatic hpd_cycle();
    @(negedge clk);
    hpd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; hpd = 1'b0; cfg_restart = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.i2c_req, bus.i2c_rw, bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata} !== 25'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h, required 0",
               {bus.i2c_req, bus.i2c_rw, bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata});
    end
    checks++;
    if ({video_en, cfg_err, cfg_idx} !== 5'd0) begin
      errors++;
      $display("FAIL reset_status: got %b, required 0", {video_en, cfg_err, cfg_idx});
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.i2c_req !== 1'b0 || n_started != 0) begin
      errors++;
      $display("FAIL idle_no_hpd: req=%0d started=%0d, required 0/0", bus.i2c_req, n_started);
    end
  endtask

  task automatic test_all_ack();
    int n, m;
    bit e;
    clear_policy(); arm(); lat = 3;
    build_expected(e);
    hpd = 1'b1;
    measure_latency(n);
    checks++;
    if (n != PWR + 1) begin
      errors++;
      $display("FAIL t1_latency: got %0d cycles, required %0d", n, PWR + 1);
    end
    wait_end("t1");
    m = log_mismatch();
    checks++;
    if (m != -1) begin
      errors++;
      $display("FAIL t1_log: bad at %0d, got %0d tx, required %0d", m, tx_q.size(), exp_q.size());
    end
    checks++;
    if ({video_en, cfg_err, cfg_idx} !== {1'b1, 1'b0, 3'd5}) begin
      errors++;
      $display("FAIL t1_status: got %b, required %b", {video_en, cfg_err, cfg_idx}, {1'b1, 1'b0, 3'd5});
    end
    hpd = 1'b0;
    #1;
    checks++;
    if (video_en !== 1'b0) begin
      errors++;
      $display("FAIL t1_video_comb: got %0d after hpd fall, required 0", video_en);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nack_retry();
    int m, c;
    bit e;
    clear_policy(); nack_cfg[8'h15] = 2; arm();
    build_expected(e);
    hpd = 1'b1;
    wait_end("t2");
    m = log_mismatch();
    checks++;
    if (m != -1) begin
      errors++;
      $display("FAIL t2_log: bad at %0d, got %0d tx, required %0d", m, tx_q.size(), exp_q.size());
    end
    c = 0;
    foreach (tx_q[i]) if (tx_q[i].r == 8'h15 && !tx_q[i].rw && tx_q[i].d == 8'h05) c++;
    checks++;
    if (c != 3) begin
      errors++;
      $display("FAIL t2_reg15_count: got %0d, required 3", c);
    end
    checks++;
    if (video_en !== 1'b1 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL t2_status: video_en=%0d cfg_err=%0d, required 1/0", video_en, cfg_err);
    end
  endtask

  task automatic test_nack_error();
    int m, snap;
    bit e;
    clear_policy(); nack_cfg[8'h98] = 255; arm();
    build_expected(e);
    @(negedge clk); cfg_restart = 1'b1;
    @(negedge clk); cfg_restart = 1'b0;
    wait_end("t3");
    m = log_mismatch();
    checks++;
    if (m != -1 || !e) begin
      errors++;
      $display("FAIL t3_log: bad at %0d, got %0d tx, required %0d", m, tx_q.size(), exp_q.size());
    end
    checks++;
    if ({video_en, cfg_err, cfg_idx} !== {1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL t3_status: got %b, required %b", {video_en, cfg_err, cfg_idx}, {1'b0, 1'b1, 3'd1});
    end
    snap = n_started;
    repeat (20) @(negedge clk);
    checks++;
    if (n_started != snap || bus.i2c_req !== 1'b0 || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL t3_quiet: started %0d req=%0d err=%0d, required %0d/0/1",
               n_started, bus.i2c_req, cfg_err, snap);
    end
    clear_policy(); arm();
    build_expected(e);
    cfg_restart = 1'b1;
    @(negedge clk); cfg_restart = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL t3_err_clear: got %0d after restart, required 0", cfg_err);
    end
    wait_end("t3r");
    m = log_mismatch();
    checks++;
    if (m != -1 || tx_q.size() == 0 || tx_q[0].r !== 8'h41 || video_en !== 1'b1) begin
      errors++;
      $display("FAIL t3_restart: bad at %0d, video_en=%0d, required full table and 1", m, video_en);
    end
  endtask

  task automatic test_hpd_drop();
    int n, m, k, snap;
    bit e;
    hpd_cycle();
    clear_policy(); arm(); lat = 6;
    hpd = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.i2c_req && bus.i2c_reg == 8'h9A) break;
    end
    hpd = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.i2c_req !== 1'b1 || bus.i2c_reg !== 8'h9A) begin
      errors++;
      $display("FAIL t4_hold: req=%0d reg=%h, required 1/9a", bus.i2c_req, bus.i2c_reg);
    end
    for (k = 0; k < 50 && tx_q.size() < 3; k++) @(negedge clk);
    snap = n_started;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.i2c_req !== 1'b0 || n_started != snap || tx_q.size() != 3 || tx_q[2].r !== 8'h9A) begin
      errors++;
      $display("FAIL t4_idle: req=%0d tx=%0d started=%0d, required 0/3/%0d",
               bus.i2c_req, tx_q.size(), n_started, snap);
    end
    arm(); lat = 3;
    build_expected(e);
    hpd = 1'b1;
    measure_latency(n);
    checks++;
    if (n != PWR + 1 || bus.i2c_reg !== 8'h41) begin
      errors++;
      $display("FAIL t4_rerise: latency %0d reg %h, required %0d/41", n, bus.i2c_reg, PWR + 1);
    end
    wait_end("t4");
    m = log_mismatch();
    checks++;
    if (m != -1 || video_en !== 1'b1) begin
      errors++;
      $display("FAIL t4_log: bad at %0d video_en=%0d, required -1/1", m, video_en);
    end
  endtask

  task automatic test_reset_mid();
    int n, m, k;
    bit e;
    hpd_cycle();
    clear_policy(); arm(); lat = 5;
    hpd = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.i2c_req && bus.i2c_reg == 8'h98) break;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.i2c_req, bus.i2c_rw, bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata, video_en, cfg_err, cfg_idx} !== 30'd0) begin
      errors++;
      $display("FAIL t5_async: got %h, required 0",
               {bus.i2c_req, bus.i2c_rw, bus.i2c_dev, bus.i2c_reg, bus.i2c_wdata, video_en, cfg_err, cfg_idx});
    end
    repeat (2) @(negedge clk);
    arm(); lat = 2;
    build_expected(e);
    rst = 1'b0;
    measure_latency(n);
    checks++;
    if (n != PWR + 1) begin
      errors++;
      $display("FAIL t5_latency: got %0d cycles, required %0d", n, PWR + 1);
    end
    wait_end("t5");
    m = log_mismatch();
    checks++;
    if (m != -1 || video_en !== 1'b1) begin
      errors++;
      $display("FAIL t5_log: bad at %0d video_en=%0d, required -1/1", m, video_en);
    end
  endtask

  task automatic test_random();
    int m, v;
    bit e;
    for (int it = 0; it < 8; it++) begin
      hpd_cycle();
      clear_policy();
      for (int i = 0; i < 6; i++) begin
        v = $urandom_range(0, 19);
        nack_cfg[t_reg[i]] = (v < 12) ? 0 : (v < 16) ? 1 : (v < 19) ? 2 : 3;
      end
      arm(); lat = $urandom_range(1, 5);
      build_expected(e);
      hpd = 1'b1;
      wait_end("rand");
      m = log_mismatch();
      checks++;
      if (m != -1) begin
        errors++;
        $display("FAIL rand%0d_log: bad at %0d, got %0d tx, required %0d", it, m, tx_q.size(), exp_q.size());
      end
      checks++;
      if (video_en !== !e || cfg_err !== e) begin
        errors++;
        $display("FAIL rand%0d_status: video_en=%0d cfg_err=%0d, required %0d/%0d",
                 it, video_en, cfg_err, !e, e);
      end
      $display("rand %0d: lat=%0d tx=%0d err=%0d", it, lat, tx_q.size(), cfg_err);
    end
  endtask

`ifdef HDMI_CFG_VERIFY_EN
  task automatic test_verify();
    int m, w, r;
    bit e;
    hpd_cycle();
    clear_policy(); bad_cfg[8'h16] = 3; arm(); lat = 3;
    build_expected(e);
    hpd = 1'b1;
    wait_end("t6");
    m = log_mismatch();
    checks++;
    if (m != -1 || !e) begin
      errors++;
      $display("FAIL t6_log: bad at %0d, got %0d tx, required %0d", m, tx_q.size(), exp_q.size());
    end
    w = 0; r = 0;
    foreach (tx_q[i]) if (tx_q[i].r == 8'h16) begin
      if (tx_q[i].rw) r++;
      else w++;
    end
    checks++;
    if (w != 3 || r != 3 || cfg_err !== 1'b1 || video_en !== 1'b0) begin
      errors++;
      $display("FAIL t6_retry: writes=%0d reads=%0d err=%0d, required 3/3/1", w, r, cfg_err);
    end
  endtask
`endif

  initial begin
    t_reg = '{8'h41, 8'h98, 8'h9A, 8'h15, 8'h16, 8'hAF};
    t_dat = '{8'h10, 8'h03, 8'hE0, 8'h05, 8'h30, 8'h06};
    foreach (dev_mem[i]) dev_mem[i] = 8'h00;
    clear_policy();
    arm();
    test_reset();
    test_all_ack();
    test_nack_retry();
    test_nack_error();
    test_hpd_drop();
    test_reset_mid();
    test_random();
`ifdef HDMI_CFG_VERIFY_EN
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
